// File: rtl/readout_packer.sv
// Packs 2-bit I/Q readout samples, eight per word, into 32-bit words and queues them in a
// first-word-fall-through FIFO. Optional per-word even parity when READOUT_PARITY_EN is defined.
module readout_packer #(
   parameter  int FIFO_DEPTH = 4,
   parameter  int SAMPLES    = 8,
   localparam int WORD_W     = 4*SAMPLES,
   localparam int CNT_W      = $clog2(FIFO_DEPTH+1),
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int IDX_W      = $clog2(SAMPLES)
) (
   input  logic              clk_master,
   input  logic              rstb,
   input  logic              ud_en,
   input  logic              frame_start,
   input  logic [1:0]        read_out_I,
   input  logic [1:0]        read_out_Q,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              overflow,
   input  logic              overflow_clr
`ifdef READOUT_PARITY_EN
   ,output logic             word_parity
`endif
);

   logic [IDX_W-1:0]  fill_q, fill_d, idx;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic              word_done;

   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_q, rd_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              empty, full, pop, push, ovf_set;

   // frame_start restarts the word at sample 0 regardless of the current fill index
   assign idx = frame_start ? '0 : fill_q;

   always_comb begin
      asm_d     = asm_q;
      fill_d    = fill_q;
      word_done = 1'b0;
      if (ud_en) begin
         if (frame_start) asm_d = '0;
         asm_d[{idx, 2'b00} +: 4] = {read_out_I, read_out_Q};
         word_done = (idx == IDX_W'(SAMPLES-1));
         fill_d    = idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_master or negedge rstb) begin
      if (!rstb) begin
         fill_q <= '0;
         asm_q  <= '0;
      end else begin
         fill_q <= fill_d;
         asm_q  <= asm_d;
      end
   end

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign pop     = !empty && word_ready;
   // a simultaneous pop frees the slot the incoming word needs
   assign push    = word_done && (!full || pop);
   assign ovf_set = word_done && full && !pop;

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
      ovf_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk_master or negedge rstb) begin
      if (!rstb) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + PTR_W'(1);
         if (pop)  rd_q <= rd_q + PTR_W'(1);
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // storage is not reset; entries are only visible while counted
   always_ff @(posedge clk_master) begin
      if (push) mem_q[wr_q] <= asm_d;
   end

   assign word_data  = empty ? '0 : mem_q[rd_q];
   assign word_valid = !empty;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;

`ifdef READOUT_PARITY_EN
   logic par_q [FIFO_DEPTH];

   always_ff @(posedge clk_master) begin
      if (push) par_q[wr_q] <= ^asm_d;
   end

   assign word_parity = !empty && par_q[rd_q];
`endif

endmodule

// File: tb/tb_readout_packer.sv
// Scoreboard bench for readout_packer: a behavioural packer/queue model predicts every word
// and status flag; scenario tasks add explicit checks of the documented results.
module tb_readout_packer;

   logic        clk_master = 1'b0;
   logic        rstb = 1'b0;
   logic        ud_en = 1'b0, frame_start = 1'b0, word_ready = 1'b0, overflow_clr = 1'b0;
   logic [1:0]  read_out_I = '0, read_out_Q = '0;
   logic [31:0] word_data;
   logic        word_valid, overflow;
   logic [2:0]  fifo_count;
`ifdef READOUT_PARITY_EN
   logic        word_parity;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] sb [$];
   int          m_fill = 0;
   logic [31:0] m_asm = '0;
   logic        m_ovf = 1'b0;

   readout_packer #(.FIFO_DEPTH(4)) dut (
      .clk_master  (clk_master),
      .rstb        (rstb),
      .ud_en       (ud_en),
      .frame_start (frame_start),
      .read_out_I  (read_out_I),
      .read_out_Q  (read_out_Q),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .overflow_clr(overflow_clr)
`ifdef READOUT_PARITY_EN
      ,.word_parity(word_parity)
`endif
   );

   always #5 clk_master = ~clk_master;

   // Model: compare state left by the previous edge, then predict the coming edge.
   always @(negedge clk_master) begin
      logic [31:0] exp;
      int          idx;
      logic        set;
      if (!rstb) begin
         sb.delete();
         m_fill = 0;
         m_asm  = '0;
         m_ovf  = 1'b0;
      end else begin
         checks++;
         if (word_valid !== (sb.size() != 0) || int'(fifo_count) != sb.size() || overflow !== m_ovf) begin
            errors++;
            $display("FAIL status: valid=%0b count=%0d ovf=%0b expected valid=%0b count=%0d ovf=%0b",
                     word_valid, fifo_count, overflow, sb.size() != 0, sb.size(), m_ovf);
         end
`ifdef READOUT_PARITY_EN
         checks++;
         if (word_parity !== ((sb.size() != 0) ? ^sb[0] : 1'b0)) begin
            errors++;
            $display("FAIL parity: got %0b expected %0b", word_parity, (sb.size() != 0) ? ^sb[0] : 1'b0);
         end
`endif
         if (sb.size() != 0 && word_ready) begin
            exp = sb.pop_front();
            checks++;
            if (word_data !== exp) begin
               errors++;
               $display("FAIL pop_data: got %h expected %h", word_data, exp);
            end
         end
         set = 1'b0;
         if (ud_en) begin
            idx = frame_start ? 0 : m_fill;
            if (frame_start) m_asm = '0;
            m_asm[idx*4 +: 4] = {read_out_I, read_out_Q};
            m_fill = (idx + 1) % 8;
            if (idx == 7) begin
               if (sb.size() < 4) sb.push_back(m_asm);
               else set = 1'b1;
            end
         end
         m_ovf = set ? 1'b1 : (overflow_clr ? 1'b0 : m_ovf);
      end
   end

   task automatic tick();
      @(posedge clk_master);
      #1;
   endtask

   task automatic sample(input logic fs, input logic [3:0] nib);
      ud_en = 1'b1;
      frame_start = fs;
      {read_out_I, read_out_Q} = nib;
      tick();
      ud_en = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 8; k++) sample(1'b0, w[k*4 +: 4]);
   endtask

   task automatic drain();
      int n = 0;
      word_ready = 1'b1;
      while (fifo_count != 0 && n < 20) begin
         tick();
         n++;
      end
      word_ready = 1'b0;
      checks++;
      if (fifo_count !== 3'd0 || word_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain: count=%0d valid=%0b expected count=0 valid=0", fifo_count, word_valid);
      end
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      #1;
      checks++;
      if (word_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || word_data !== 32'h0) begin
         errors++;
         $display("FAIL reset: valid=%0b count=%0d ovf=%0b data=%h expected all 0",
                  word_valid, fifo_count, overflow, word_data);
      end
      tick();
      tick();
      rstb = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      for (int k = 0; k < 8; k++) sample(1'b0, 4'b1001);
      checks++;
      if (word_valid !== 1'b1 || word_data !== 32'h9999_9999 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL basic: valid=%0b data=%h count=%0d expected 1 99999999 1", word_valid, word_data, fifo_count);
      end
      drain();
   endtask

   task automatic test_gap();
      for (int k = 0; k < 4; k++) sample(1'b0, 4'(k));
      repeat (3) tick();
      checks++;
      if (word_valid !== 1'b0) begin
         errors++;
         $display("FAIL gap_early: valid=%0b expected 0", word_valid);
      end
      for (int k = 4; k < 8; k++) sample(1'b0, 4'(k));
      checks++;
      if (word_data !== 32'h7654_3210 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL gap: data=%h count=%0d expected 76543210 1", word_data, fifo_count);
      end
      drain();
   endtask

   task automatic test_frame_start();
      for (int k = 0; k < 5; k++) sample(1'b0, 4'h5);
      sample(1'b1, 4'hF);
      for (int k = 0; k < 7; k++) sample(1'b0, 4'h0);
      checks++;
      if (word_data !== 32'h0000_000F || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL frame_start: data=%h count=%0d expected 0000000f 1", word_data, fifo_count);
      end
      drain();
   endtask

   task automatic test_overflow();
      word_ready = 1'b0;
      for (int w = 1; w <= 5; w++) send_word({8{4'(w)}});
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1 || word_data !== 32'h1111_1111) begin
         errors++;
         $display("FAIL overflow: count=%0d ovf=%0b head=%h expected 4 1 11111111", fifo_count, overflow, word_data);
      end
      drain();
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: ovf=%0b expected 1", overflow);
      end
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clr: ovf=%0b expected 0", overflow);
      end
   endtask

   task automatic test_full_push_pop();
      for (int w = 0; w < 4; w++) send_word(32'hA0B1_C2D3 + 32'(w));
      for (int k = 0; k < 7; k++) sample(1'b0, 4'hE);
      word_ready = 1'b1;
      sample(1'b0, 4'h3);
      word_ready = 1'b0;
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b0 || word_data !== 32'hA0B1_C2D4) begin
         errors++;
         $display("FAIL full_push_pop: count=%0d ovf=%0b head=%h expected 4 0 a0b1c2d4",
                  fifo_count, overflow, word_data);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      send_word(32'h1234_5678);
      send_word(32'h8765_4321);
      for (int k = 0; k < 3; k++) sample(1'b0, 4'h7);
      rstb = 1'b0;
      #1;
      checks++;
      if (word_valid !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid: valid=%0b count=%0d expected 0 0", word_valid, fifo_count);
      end
      tick();
      rstb = 1'b1;
      tick();
      send_word(32'hAAAA_AAAA);
      checks++;
      if (word_data !== 32'hAAAA_AAAA || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL reset_clean: data=%h count=%0d expected aaaaaaaa 1", word_data, fifo_count);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      word_ready = 1'b1;
      for (int w = 0; w < 6; w++) send_word($urandom());
      word_ready = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_frame_start();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      test_back_to_back();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
